mc_controller_ext: RTL and testbench



---
 rtl/mc_controller_ext_if.sv | 55 +++++
 rtl/mc_controller_ext.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_mc_controller_ext.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_ext_if.sv
// -----------------------------------------------------------------------------
// mc_controller_ext_if
//
// Bundle of signals between the multicycle MIPS controller and its datapath.
//
//   Instruction/status (datapath -> controller):
//     op[5:0], funct[5:0]   fields of the latched instruction register
//     zero                  ALU zero flag
//     mem_ready             memory access completes this cycle
//   Controls (controller -> datapath):
//     IorD, IRwrite, memwrite, memtoreg, regwrite, regdst, alusrcA, pcEn
//     alusrcB[1:0], pcsrc[1:0], alucontrol[ACW-1:0], zeroext
//   Status (controller -> observer):
//     fault                 one-cycle pulse (illegal opcode / watchdog)
//     state[3:0]            current FSM state code
//
// Modports:
//   master - the controller (drives controls, reads instruction/status)
//   slave  - the datapath side (drives instruction/status, reads controls)
// -----------------------------------------------------------------------------
interface mc_controller_ext_if #(
    parameter int ACW = 3
);
    logic [5:0]     op;
    logic [5:0]     funct;
    logic           zero;
    logic           mem_ready;

    logic           IorD;
    logic           IRwrite;
    logic           memwrite;
    logic           memtoreg;
    logic           regwrite;
    logic           regdst;
    logic           alusrcA;
    logic           pcEn;
    logic [1:0]     alusrcB;
    logic [1:0]     pcsrc;
    logic [ACW-1:0] alucontrol;
    logic           zeroext;
    logic           fault;
    logic [3:0]     state;

    modport master (
        input  op, funct, zero, mem_ready,
        output IorD, IRwrite, memwrite, memtoreg, regwrite, regdst, alusrcA,
               pcEn, alusrcB, pcsrc, alucontrol, zeroext, fault, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  IorD, IRwrite, memwrite, memtoreg, regwrite, regdst, alusrcA,
               pcEn, alusrcB, pcsrc, alucontrol, zeroext, fault, state
    );
endinterface

// File: rtl/mc_controller_ext.sv
// -----------------------------------------------------------------------------
// mc_controller_ext
//
// Multicycle MIPS controller: main FSM plus ALU decoder. Supports lw, sw,
// R-type, beq, bne, addi and j; optionally andi/ori. Memory states (FETCH,
// MEMRD, MEMWR) can wait on a memory ready handshake guarded by a watchdog.
//
// Parameters:
//   ACW           alucontrol width (>= 3); bits above [2:0] are driven 0
//   MEM_HANDSHAKE 1: memory states wait for mem_ready; 0: mem_ready ignored
//   TIMEOUT       max consecutive wait cycles in one memory state; 0 = off
//
// Optional feature macro:
//   MC_CTRL_IMM_LOGIC_EN  when defined, andi (001100) / ori (001101) execute
//                         through IMMEX with zero-extended immediates; when
//                         undefined they are illegal opcodes and zeroext = 0.
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-high
//   bus    mc_controller_ext_if.master (instruction fields, zero, mem_ready
//          in; datapath controls, fault pulse and debug state out)
// -----------------------------------------------------------------------------
module mc_controller_ext #(
    parameter int ACW           = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    mc_controller_ext_if.master    bus
);

    // Watchdog counter must be able to hold TIMEOUT; keep at least one bit.
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12,
        S_IMMEX   = 4'd13
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            fault_reg, fault_next;

    logic            rdy;
    logic            wd_active;
    logic            timeout;
    logic            illegal;

    logic            iord_c, irwrite_c, memwrite_c, memtoreg_c;
    logic            regwrite_c, regdst_c, alusrca_c, pcen_c;
    logic [1:0]      alusrcb_c, pcsrc_c, aluop_c;
    logic [2:0]      alu3;
`ifdef MC_CTRL_IMM_LOGIC_EN
    logic            zeroext_c;
`endif

    // Without the handshake every memory access is assumed single-cycle.
    assign rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

    // Only states that talk to memory can wait and therefore time out.
    assign wd_active = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                       (state_reg == S_MEMWR);
    assign timeout   = (TIMEOUT != 0) && wd_active && !rdy &&
                       (cnt_reg == CW'(TIMEOUT));

    // -------------------------------------------------------------------------
    // State, watchdog counter and fault pulse registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fault_reg <= fault_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore control decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        illegal    = 1'b0;
        iord_c     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        regdst_c   = 1'b0;
        alusrca_c  = 1'b0;
        pcen_c     = 1'b0;
        alusrcb_c  = 2'b00;
        pcsrc_c    = 2'b00;
        aluop_c    = 2'b00;
`ifdef MC_CTRL_IMM_LOGIC_EN
        zeroext_c  = 1'b0;
`endif

        case (state_reg)
            S_FETCH: begin
                // PC+4 and IR load only happen on the cycle the fetch lands.
                alusrcb_c = 2'b01;
                irwrite_c = rdy;
                pcen_c    = rdy;
                if (rdy)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the op is decoded.
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_BNE:       state_next = S_BNE;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
`ifdef MC_CTRL_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_next = S_IMMEX;
`endif
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = 2'b10;
                state_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
                if (rdy)
                    state_next = S_MEMWB;
                else if (timeout)
                    state_next = S_FETCH;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                // A timed-out write is abandoned: memwrite drops with the
                // move to FETCH.
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (rdy || timeout)
                    state_next = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca_c  = 1'b1;
                aluop_c    = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alusrca_c  = 1'b1;
                aluop_c    = 2'b01;
                pcsrc_c    = 2'b01;
                pcen_c     = bus.zero;
                state_next = S_FETCH;
            end
            S_BNE: begin
                alusrca_c  = 1'b1;
                aluop_c    = 2'b01;
                pcsrc_c    = 2'b01;
                pcen_c     = ~bus.zero;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = 2'b10;
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_c    = 2'b10;
                pcen_c     = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MC_CTRL_IMM_LOGIC_EN
            S_IMMEX: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = 2'b10;
                aluop_c    = 2'b11;
                zeroext_c  = 1'b1;
                state_next = S_IMMWB;
            end
`endif
            default: begin
                // Unused codes (and IMMEX when the feature is off) recover.
                state_next = S_FETCH;
            end
        endcase

        // Watchdog expiry in FETCH keeps the FSM in FETCH (already the case
        // above since rdy is low); in MEMRD/MEMWR it was redirected to FETCH.
    end

    // -------------------------------------------------------------------------
    // Watchdog counter: counts consecutive not-ready cycles within one visit
    // to a memory state; any state change, ready or expiry restarts it.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next = '0;
        if ((TIMEOUT != 0) && wd_active && !rdy && !timeout &&
            (state_next == state_reg))
            cnt_next = cnt_reg + 1'b1;
    end

    assign fault_next = illegal | timeout;

    // -------------------------------------------------------------------------
    // ALU decoder
    // -------------------------------------------------------------------------
    always_comb begin
        alu3 = 3'b010;
        case (aluop_c)
            2'b00: alu3 = 3'b010;
            2'b01: alu3 = 3'b110;
            2'b10: begin
                case (bus.funct)
                    FN_ADD:  alu3 = 3'b010;
                    FN_SUB:  alu3 = 3'b110;
                    FN_AND:  alu3 = 3'b000;
                    FN_OR:   alu3 = 3'b001;
                    FN_SLT:  alu3 = 3'b111;
                    default: alu3 = 3'b000;
                endcase
            end
            default: alu3 = (bus.op == OP_ANDI) ? 3'b000 : 3'b001;
        endcase
    end

    // Widen the 3-bit ALU function to ACW bits with zero padding.
    genvar gi;
    generate
        for (gi = 0; gi < ACW; gi++) begin : g_aluc
            if (gi < 3) begin : g_lo
                assign bus.alucontrol[gi] = alu3[gi];
            end else begin : g_hi
                assign bus.alucontrol[gi] = 1'b0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output drive
    // -------------------------------------------------------------------------
    assign bus.IorD     = iord_c;
    assign bus.IRwrite  = irwrite_c;
    assign bus.memwrite = memwrite_c;
    assign bus.memtoreg = memtoreg_c;
    assign bus.regwrite = regwrite_c;
    assign bus.regdst   = regdst_c;
    assign bus.alusrcA  = alusrca_c;
    assign bus.pcEn     = pcen_c;
    assign bus.alusrcB  = alusrcb_c;
    assign bus.pcsrc    = pcsrc_c;
    assign bus.fault    = fault_reg;
    assign bus.state    = state_reg;
`ifdef MC_CTRL_IMM_LOGIC_EN
    assign bus.zeroext  = zeroext_c;
`else
    assign bus.zeroext  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller_ext.sv
// -----------------------------------------------------------------------------
// tb_mc_controller_ext
//
// Self-checking bench for mc_controller_ext (ACW=4, MEM_HANDSHAKE=1,
// TIMEOUT=3). Instructions are expanded into per-cycle expectations from the
// instruction's state path, and each cycle's full control vector is compared.
// -----------------------------------------------------------------------------
module tb_mc_controller_ext;

    localparam int ACW     = 4;
    localparam int TIMEOUT = 3;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mc_controller_ext_if #(.ACW(ACW)) bus ();

    mc_controller_ext #(
        .ACW(ACW), .MEM_HANDSHAKE(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         st;
        bit         rdy;
        logic [5:0] op;
        logic [5:0] funct;
        bit         z;
        bit         flt;
    } cyc_t;

    cyc_t stream[$];
    bit   pend_fault;
    bit   cur_z_rand;
    bit   cur_z;

    // ALU function from the decoder table.
    function automatic logic [2:0] alu_of(logic [1:0] aluop, logic [5:0] op,
                                          logic [5:0] funct);
        case (aluop)
            2'd0: return 3'b010;
            2'd1: return 3'b110;
            2'd2: begin
                case (funct)
                    6'b100000: return 3'b010;
                    6'b100010: return 3'b110;
                    6'b100100: return 3'b000;
                    6'b100101: return 3'b001;
                    6'b101010: return 3'b111;
                    default:   return 3'b000;
                endcase
            end
            default: return (op == ANDI) ? 3'b000 : 3'b001;
        endcase
    endfunction

    // Expected control vector for one cycle, from the per-state output table.
    function automatic logic [21:0] spec_out(int st, bit rdy, logic [5:0] op,
                                             logic [5:0] funct, bit z, bit flt);
        bit iord = 0, irw = 0, mw = 0, m2r = 0, rw = 0, rd = 0, sa = 0, pce = 0;
        bit ze = 0;
        logic [1:0] sb = 2'd0, ps = 2'd0, aluop = 2'd0;
        case (st)
            0:  begin sb = 2'd1; irw = rdy; pce = rdy; end
            1:  sb = 2'd3;
            2:  begin sa = 1; sb = 2'd2; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; aluop = 2'd2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; aluop = 2'd1; ps = 2'd1; pce = z; end
            9:  begin sa = 1; sb = 2'd2; end
            10: rw = 1;
            11: begin ps = 2'd2; pce = 1; end
            12: begin sa = 1; aluop = 2'd1; ps = 2'd1; pce = !z; end
            13: begin sa = 1; sb = 2'd2; aluop = 2'd3; ze = 1; end
            default: ;
        endcase
        return {iord, irw, mw, m2r, rw, rd, sa, pce, sb, ps,
                {1'b0, alu_of(aluop, op, funct)}, ze, flt, 4'(st)};
    endfunction

    function automatic void push_cyc(int st, bit rdy, logic [5:0] op,
                                     logic [5:0] funct);
        cyc_t c;
        c.st    = st;
        c.rdy   = rdy;
        c.op    = op;
        c.funct = funct;
        c.z     = cur_z_rand ? 1'($urandom % 2) : cur_z;
        c.flt   = pend_fault;
        pend_fault = 0;
        stream.push_back(c);
    endfunction

    // Expand one instruction into its cycle-by-cycle state path.
    // fw = FETCH wait cycles, mw = wait cycles in MEMRD/MEMWR (both < TIMEOUT).
    function automatic void push_instr(logic [5:0] op, logic [5:0] funct,
                                       int zsel, int fw, int mw);
        cur_z_rand = (zsel < 0);
        cur_z      = (zsel > 0);
        for (int i = 0; i < fw; i++) push_cyc(0, 0, op, funct);
        push_cyc(0, 1, op, funct);
        push_cyc(1, 1'($urandom % 2), op, funct);
        case (op)
            LW: begin
                push_cyc(2, 1'($urandom % 2), op, funct);
                for (int i = 0; i < mw; i++) push_cyc(3, 0, op, funct);
                push_cyc(3, 1, op, funct);
                push_cyc(4, 1'($urandom % 2), op, funct);
            end
            SW: begin
                push_cyc(2, 1'($urandom % 2), op, funct);
                for (int i = 0; i < mw; i++) push_cyc(5, 0, op, funct);
                push_cyc(5, 1, op, funct);
            end
            RT: begin
                push_cyc(6, 1'($urandom % 2), op, funct);
                push_cyc(7, 1'($urandom % 2), op, funct);
            end
            BEQ:  push_cyc(8, 1'($urandom % 2), op, funct);
            BNE:  push_cyc(12, 1'($urandom % 2), op, funct);
            ADDI: begin
                push_cyc(9, 1'($urandom % 2), op, funct);
                push_cyc(10, 1'($urandom % 2), op, funct);
            end
            JMP:  push_cyc(11, 1'($urandom % 2), op, funct);
`ifdef MC_CTRL_IMM_LOGIC_EN
            ANDI, ORI: begin
                push_cyc(13, 1'($urandom % 2), op, funct);
                push_cyc(10, 1'($urandom % 2), op, funct);
            end
`endif
            default: pend_fault = 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        step();
        reset = 1'b0;
        pend_fault = 0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [21:0] got, exp;
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus.op        = 6'($urandom);
            bus.funct     = 6'($urandom);
            bus.zero      = 1'($urandom % 2);
            bus.mem_ready = r[0];
            step();
            @(negedge clk);
            got = {bus.IorD, bus.IRwrite, bus.memwrite, bus.memtoreg,
                   bus.regwrite, bus.regdst, bus.alusrcA, bus.pcEn,
                   bus.alusrcB, bus.pcsrc, bus.alucontrol, bus.zeroext,
                   bus.fault, bus.state};
            exp = spec_out(0, r[0], bus.op, bus.funct, bus.zero, 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_values rdy=%0d got %h expected %h", r, got, exp);
            end
            $display("reset rdy=%0d controls %h", r, got);
        end
        step();
        reset = 1'b0;
    endtask

    // Directed instruction table: covers lw path, every funct, branches with
    // both zero values, addi, j, illegal op and andi/ori.
    task automatic test_instructions();
        logic [21:0] got, exp;
        do_reset();
        push_instr(LW,   6'd0,       0, 0, 0);
        push_instr(RT,   6'b101010,  0, 0, 0);
        push_instr(RT,   6'b100000,  0, 1, 0);
        push_instr(RT,   6'b100010,  0, 0, 0);
        push_instr(RT,   6'b100100,  0, 0, 0);
        push_instr(RT,   6'b100101,  0, 0, 0);
        push_instr(RT,   6'b000111,  0, 0, 0);
        push_instr(BEQ,  6'd0,       1, 0, 0);
        push_instr(BEQ,  6'd0,       0, 0, 0);
        push_instr(BNE,  6'd0,       1, 0, 0);
        push_instr(BNE,  6'd0,       0, 0, 0);
        push_instr(SW,   6'd0,       0, 0, 2);
        push_instr(ADDI, 6'd0,       0, 0, 0);
        push_instr(JMP,  6'd0,       0, 0, 0);
        push_instr(6'b111111, 6'd0,  0, 0, 0);
        push_instr(ORI,  6'd0,       0, 0, 0);
        push_instr(ANDI, 6'd0,       0, 0, 0);
        push_instr(LW,   6'd0,       0, 2, 2);
        push_cyc(0, 0, LW, 6'd0);
        for (int i = 0; i < stream.size(); i++) begin
            bus.op = stream[i].op; bus.funct = stream[i].funct;
            bus.zero = stream[i].z; bus.mem_ready = stream[i].rdy;
            @(negedge clk);
            got = {bus.IorD, bus.IRwrite, bus.memwrite, bus.memtoreg,
                   bus.regwrite, bus.regdst, bus.alusrcA, bus.pcEn,
                   bus.alusrcB, bus.pcsrc, bus.alucontrol, bus.zeroext,
                   bus.fault, bus.state};
            exp = spec_out(stream[i].st, stream[i].rdy, stream[i].op,
                           stream[i].funct, stream[i].z, stream[i].flt);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL directed cyc=%0d op=%b got %h expected %h", i, stream[i].op, got, exp);
            end
            $display("directed cyc=%0d op=%b state=%0d controls %h", i, stream[i].op, bus.state, got);
            step();
        end
        stream.delete();
    endtask

    // Watchdog: sw stalled in MEMWR, then FETCH stalled past TIMEOUT.
    task automatic test_watchdog();
        logic [21:0] got, exp;
        do_reset();
        cur_z_rand = 1;
        push_cyc(0, 1, SW, 6'd0);
        push_cyc(1, 1, SW, 6'd0);
        push_cyc(2, 1, SW, 6'd0);
        for (int i = 0; i <= TIMEOUT; i++) push_cyc(5, 0, SW, 6'd0);
        pend_fault = 1;
        push_cyc(0, 0, SW, 6'd0);            // fault pulse, memwrite gone
        push_cyc(0, 0, SW, 6'd0);            // pulse is exactly one cycle
        push_cyc(0, 1, SW, 6'd0);
        push_cyc(1, 1, LW, 6'd0);
        push_cyc(2, 1, LW, 6'd0);
        for (int i = 0; i <= TIMEOUT; i++) push_cyc(3, 0, LW, 6'd0);
        pend_fault = 1;
        for (int i = 0; i <= TIMEOUT; i++) push_cyc(0, 0, LW, 6'd0);
        pend_fault = 1;                      // FETCH expiry stays in FETCH
        for (int i = 0; i < TIMEOUT; i++) push_cyc(0, 0, LW, 6'd0);
        push_cyc(0, 1, LW, 6'd0);            // counter restarted after expiry
        push_cyc(1, 1, LW, 6'd0);
        for (int i = 0; i < stream.size(); i++) begin
            bus.op = stream[i].op; bus.funct = stream[i].funct;
            bus.zero = stream[i].z; bus.mem_ready = stream[i].rdy;
            @(negedge clk);
            got = {bus.IorD, bus.IRwrite, bus.memwrite, bus.memtoreg,
                   bus.regwrite, bus.regdst, bus.alusrcA, bus.pcEn,
                   bus.alusrcB, bus.pcsrc, bus.alucontrol, bus.zeroext,
                   bus.fault, bus.state};
            exp = spec_out(stream[i].st, stream[i].rdy, stream[i].op,
                           stream[i].funct, stream[i].z, stream[i].flt);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL watchdog cyc=%0d got %h expected %h", i, got, exp);
            end
            $display("watchdog cyc=%0d state=%0d fault=%0d controls %h", i, bus.state, bus.fault, got);
            step();
        end
        stream.delete();
    endtask

    // Reset in MEMRD and in DECODE of an illegal op.
    task automatic test_reset_mid();
        logic [21:0] got, exp;
        do_reset();
        bus.op = LW; bus.funct = 6'd0; bus.zero = 0; bus.mem_ready = 1;
        step(); step(); step();
        bus.mem_ready = 0;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd3) begin
            errors++;
            $display("FAIL reset_mid_reach_memrd state %0d expected 3", bus.state);
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        got = {bus.IorD, bus.IRwrite, bus.memwrite, bus.memtoreg,
               bus.regwrite, bus.regdst, bus.alusrcA, bus.pcEn,
               bus.alusrcB, bus.pcsrc, bus.alucontrol, bus.zeroext,
               bus.fault, bus.state};
        exp = spec_out(0, 0, LW, 6'd0, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_memrd got %h expected %h", got, exp);
        end
        $display("reset in MEMRD -> controls %h", got);
        reset = 1'b0;
        bus.op = 6'b111111; bus.mem_ready = 1;
        step();
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL reset_mid_reach_decode state %0d expected 1", bus.state);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.fault !== 1'b0 || bus.state !== 4'd0) begin
                errors++;
                $display("FAIL reset_mid_decode cyc=%0d fault %0d state %0d expected fault 0 state 0", i, bus.fault, bus.state);
            end
            $display("reset in DECODE cyc=%0d fault=%0d state=%0d", i, bus.fault, bus.state);
            step();
        end
    endtask

    // Random instruction stream with random waits, funct and zero.
    task automatic test_random();
        logic [21:0] got, exp;
        logic [5:0]  pool [14];
        logic [5:0]  op, fn;
        pool = '{LW, SW, RT, RT, BEQ, BNE, ADDI, JMP, ANDI, ORI,
                 6'b111111, 6'b000001, 6'b001010, 6'b100000};
        do_reset();
        for (int n = 0; n < 80; n++) begin
            op = pool[$urandom_range(0, 13)];
            fn = ($urandom % 3 == 0) ? 6'($urandom) :
                 6'(32 + 2 * $urandom_range(0, 5));
            push_instr(op, fn, -1, $urandom_range(0, TIMEOUT - 1),
                       $urandom_range(0, TIMEOUT - 1));
        end
        push_cyc(0, 0, RT, 6'd0);
        for (int i = 0; i < stream.size(); i++) begin
            bus.op = stream[i].op; bus.funct = stream[i].funct;
            bus.zero = stream[i].z; bus.mem_ready = stream[i].rdy;
            @(negedge clk);
            got = {bus.IorD, bus.IRwrite, bus.memwrite, bus.memtoreg,
                   bus.regwrite, bus.regdst, bus.alusrcA, bus.pcEn,
                   bus.alusrcB, bus.pcsrc, bus.alucontrol, bus.zeroext,
                   bus.fault, bus.state};
            exp = spec_out(stream[i].st, stream[i].rdy, stream[i].op,
                           stream[i].funct, stream[i].z, stream[i].flt);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc=%0d op=%b funct=%b got %h expected %h", i, stream[i].op, stream[i].funct, got, exp);
            end
            $display("random cyc=%0d op=%b state=%0d controls %h", i, stream[i].op, bus.state, got);
            step();
        end
        stream.delete();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        pend_fault    = 0;
        cur_z_rand    = 1;
        cur_z         = 0;
        reset         = 1'b1;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        test_reset();
        test_instructions();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
